// File: rtl/timer_controller.sv
// Microwave timer sequencer: keypad entry buffer, load/run/pause/done FSM,
// 1 Hz-style decrement enable for the BCD counter chain, magnetron and beeper drive.
module timer_controller #(
    parameter int TICK_DIV   = 100,
    parameter int BEEP_TICKS = 3
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        start,
    input  logic        stop_clear,
    input  logic        door_closed,
    input  logic        cnt_zero,
    output logic [15:0] load_data,
    output logic        loadn,
    output logic        cnt_en,
    output logic        mag_on,
    output logic        beep,
    output logic [2:0]  state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS + 1) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);

    // Handshake: key_valid/start/stop_clear are single-cycle strobes sampled on
    // the rising edge; no back-pressure, a strobe not acted on is simply lost.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          cur, nxt;
    logic [15:0]     buffer, buffer_nxt;
    logic [PW-1:0]   presc, presc_nxt, presc_inc;
    logic [BW-1:0]   beep_cnt, beep_cnt_nxt;
    logic            clr_pend, clr_pend_nxt;
    logic            cnt_en_nxt;
    logic            wrap, key_ok, entry_ok;

    assign wrap      = (presc == PRESC_MAX);
    assign presc_inc = wrap ? '0 : presc + 1'b1;
    assign key_ok    = key_valid && (key_digit <= 4'd9);
    assign entry_ok  = (buffer != 16'h0000) && (buffer[7:4] <= 4'd5);
    assign load_data = buffer;
    assign state     = cur;

    always_comb begin
        nxt          = cur;
        buffer_nxt   = buffer;
        presc_nxt    = presc;
        beep_cnt_nxt = beep_cnt;
        clr_pend_nxt = clr_pend;
        cnt_en_nxt   = 1'b0;
        case (cur)
            S_IDLE: begin
                if (stop_clear) begin
                    buffer_nxt = '0;
                end else if (!start && key_ok) begin
                    buffer_nxt = {buffer[11:0], key_digit};
                    nxt        = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (stop_clear) begin
                    buffer_nxt = '0;
                    nxt        = S_IDLE;
                end else if (start) begin
                    if (entry_ok) begin
                        clr_pend_nxt = 1'b0;
                        nxt          = S_LOAD;
                    end
                end else if (key_ok) begin
                    buffer_nxt = {buffer[11:0], key_digit};
                end
            end
            S_LOAD: begin
                // Shared by normal loads and the pause-clear, which loads zero.
                presc_nxt    = '0;
                clr_pend_nxt = 1'b0;
                nxt          = clr_pend ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (!door_closed || stop_clear) begin
                    nxt = S_PAUSE;
                end else if (cnt_zero) begin
                    presc_nxt    = '0;
                    beep_cnt_nxt = '0;
                    nxt          = S_DONE;
                end else begin
                    presc_nxt  = presc_inc;
                    cnt_en_nxt = wrap;
                end
            end
            S_PAUSE: begin
                if (stop_clear) begin
                    buffer_nxt   = '0;
                    clr_pend_nxt = 1'b1;
                    nxt          = S_LOAD;
                end else if (start && door_closed) begin
                    nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (stop_clear) begin
                    buffer_nxt = '0;
                    nxt        = S_IDLE;
                end else begin
                    presc_nxt = presc_inc;
                    if (wrap) begin
                        if (beep_cnt == BEEP_LAST) begin
                            beep_cnt_nxt = '0;
                            buffer_nxt   = '0;
                            nxt          = S_IDLE;
                        end else begin
                            beep_cnt_nxt = beep_cnt + 1'b1;
                        end
                    end
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cur      <= S_IDLE;
            buffer   <= '0;
            presc    <= '0;
            beep_cnt <= '0;
            clr_pend <= 1'b0;
            loadn    <= 1'b1;
            cnt_en   <= 1'b0;
            mag_on   <= 1'b0;
            beep     <= 1'b0;
        end else begin
            cur      <= nxt;
            buffer   <= buffer_nxt;
            presc    <= presc_nxt;
            beep_cnt <= beep_cnt_nxt;
            clr_pend <= clr_pend_nxt;
            loadn    <= (nxt != S_LOAD);
            cnt_en   <= cnt_en_nxt;
            mag_on   <= (nxt == S_RUN);
            beep     <= (nxt == S_DONE);
        end
    end

endmodule
